j1_io_bridge: RTL and testbench
===============================

// Module: j1_io_bridge
// PURPOSE
//  Initiator side of the J1 peripheral bus: turns J1 io_rd/io_wr cycles into per-peripheral
//  cs/rd/wr/addr strobes and returns registered read data. Stalls the CPU through each access.
//  Sits between the J1 core and the peripherals (timer, uart, gpio...).
// PARAMETERS
//  N_PER      4      number of peripheral slots (1..15); slot k owns io_addr[7:4]==k
//  BASE_PAGE  8'h60  io_addr[15:8] value that selects the peripheral bus
// PORTS
//  clk        in   1         system clock
//  reset      in   1         asynchronous, active-high reset
//  io_rd      in   1         J1 read request, held while io_busy=1
//  io_wr      in   1         J1 write request, held while io_busy=1
//  io_addr    in   16        J1 I/O address
//  io_dout    in   16        J1 write data
//  io_din     out  16        read data to J1, valid in DONE, held until next read completes
//  io_busy    out  1         stall to J1
//  per_cs     out  N_PER     one-hot chip select
//  per_addr   out  4         register offset = io_addr[3:0]
//  per_rd     out  1         read strobe
//  per_wr     out  1         write strobe
//  per_d_in   out  16        write data to peripherals
//  per_d_out  in   16*N_PER  read data; slot k at [16k+15:16k]
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE; per_cs=0, per_rd=per_wr=0, per_addr=0, per_d_in=0,
//   io_din=0, io_busy=0. Reset mid-access aborts it; strobes drop without a clock edge.
//  FSM IDLE -> STB1 -> STB2 -> DONE -> IDLE.
//  IDLE: on io_rd|io_wr latch addr/data/dir/slot, go STB1. io_busy=1 combinationally the same cycle.
//   io_rd&io_wr together = write; read ignored.
//  Decode: hit = io_addr[15:8]==BASE_PAGE && io_addr[7:4]<N_PER. Miss: strobes and cs stay low,
//   FSM still runs full sequence; read returns 16'h0000; write discarded.
//  STB1, STB2: per_cs[slot]=1, per_rd or per_wr=1, per_addr, per_d_in stable (all registered).
//   Exactly 2 cycles: responder acks on 1st edge, self-blocks the 2nd; a 3rd would re-trigger.
//  End of STB2: io_din <= per_d_out[slot] (registered by responder at end of STB1).
//  DONE: strobes/cs low, io_busy=0, io_din valid. Request seen in DONE ignored; next access
//   needs a return to IDLE. Fixed latency: 4 cycles request-to-DONE.
//  Writes never change io_din. Exactly one per_cs bit high at most, only in STB1/STB2.
// CONFIGURATION
//  BRIDGE_ERR_EN defined: sticky err_flag and err_addr[15:0] registers; miss access sets
//   err_flag, captures io_addr (first miss only). Extra ports err_out (=err_flag) and
//   err_clr (in, 1-cycle pulse clears flag; set wins if simultaneous). Reset clears both.
//  Undefined: no error registers or ports; misses silently complete as above.
// STRUCTURE
//  Package j1_io_pkg: IO_DW=16, IO_AW=16, PER_AW=4, state enum {IDLE,STB1,STB2,DONE},
//   slot field positions [7:4], page field [15:8].
//  Sub-module j1_io_decode: combinational hit/slot/one-hot cs from io_addr.
// TESTING
//  1 Write 16'h1234 to 16'h6014 -> per_cs=4'b0010, per_wr=1, per_addr=4, per_d_in=16'h1234 for
//    exactly 2 cycles; io_busy 1 for 3 cycles, 0 in DONE.
//  2 Read 16'h6026 with timer-style responder in slot 2 returning 16'h00AB -> io_din=16'h00AB in
//    DONE, held through following writes; responder sees exactly one p_rd.
//  3 Read 16'h7003 (page miss) and 16'h6050 (slot>=N_PER) -> per_cs stays 0, io_din=0, latency 4;
//    with BRIDGE_ERR_EN err_out=1, err_addr=16'h7003 kept after second miss.
//  4 io_rd=io_wr=1 to 16'h6000 -> write only, per_rd never high, io_din unchanged.
//  5 Assert reset during STB1 of a write -> per_cs/per_wr low immediately, io_busy=0, io_din=0;
//    access after release completes normally.
//  6 Back-to-back reads held through DONE -> second access starts only from IDLE; no strobe in DONE.

Source files
------------

// File: rtl/j1_io_pkg.sv
// Shared widths, address field positions and bridge state type for the J1 I/O bridge.
// Field helpers keep the page/slot split in one place for the decoder and bench-facing docs.
package j1_io_pkg;

  localparam int IO_DW  = 16;
  localparam int IO_AW  = 16;
  localparam int PER_AW = 4;

  localparam int SLOT_LSB = 4;
  localparam int SLOT_MSB = 7;
  localparam int PAGE_LSB = 8;
  localparam int PAGE_MSB = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STB1 = 2'd1,
    STB2 = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic [3:0] slot_of(input logic [IO_AW-1:0] addr);
    return addr[SLOT_MSB:SLOT_LSB];
  endfunction

  function automatic logic [7:0] page_of(input logic [IO_AW-1:0] addr);
    return addr[PAGE_MSB:PAGE_LSB];
  endfunction

  function automatic logic [PER_AW-1:0] offset_of(input logic [IO_AW-1:0] addr);
    return addr[PER_AW-1:0];
  endfunction

endpackage

// File: rtl/j1_io_decode.sv
// Combinational address decode for the J1 peripheral bus: page match, slot number
// and one-hot chip select (all zero on a miss).
module j1_io_decode
  import j1_io_pkg::*;
#(
  parameter int          N_PER     = 4,
  parameter logic [7:0]  BASE_PAGE = 8'h60
) (
  input  logic [IO_AW-1:0] addr,
  output logic             hit,
  output logic [3:0]       slot,
  output logic [N_PER-1:0] cs
);

  always_comb begin
    slot = slot_of(addr);
    hit  = (page_of(addr) == BASE_PAGE) && (int'(slot) < N_PER);
    cs   = '0;
    for (int k = 0; k < N_PER; k++) begin
      if (hit && (slot == 4'(k))) cs[k] = 1'b1;
    end
  end

endmodule

// File: rtl/j1_io_bridge.sv
// J1 I/O bus initiator: IDLE -> STB1 -> STB2 -> DONE per access, registered strobes/read data.
// Optional BRIDGE_ERR_EN adds a sticky miss flag with captured address (err_out/err_addr/err_clr).
module j1_io_bridge
  import j1_io_pkg::*;
#(
  parameter int         N_PER     = 4,
  parameter logic [7:0] BASE_PAGE = 8'h60
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   io_rd,
  input  logic                   io_wr,
  input  logic [IO_AW-1:0]       io_addr,
  input  logic [IO_DW-1:0]       io_dout,
  output logic [IO_DW-1:0]       io_din,
  output logic                   io_busy,
  output logic [N_PER-1:0]       per_cs,
  output logic [PER_AW-1:0]      per_addr,
  output logic                   per_rd,
  output logic                   per_wr,
  output logic [IO_DW-1:0]       per_d_in,
  input  logic [IO_DW*N_PER-1:0] per_d_out
`ifdef BRIDGE_ERR_EN
  ,
  input  logic                   err_clr,
  output logic                   err_out,
  output logic [IO_AW-1:0]       err_addr
`endif
);

  state_t           state_q, state_d;
  logic             busy;
  logic             accept;
  logic             strobe_end;
  logic             wr_q;
  logic             hit_q;
  logic [3:0]       slot_q;
  logic             dec_hit;
  logic [3:0]       dec_slot;
  logic [N_PER-1:0] dec_cs;
  logic [IO_DW-1:0] rd_sel;

  j1_io_decode #(
    .N_PER     (N_PER),
    .BASE_PAGE (BASE_PAGE)
  ) u_decode (
    .addr (io_addr),
    .hit  (dec_hit),
    .slot (dec_slot),
    .cs   (dec_cs)
  );

  always_comb begin
    state_d    = state_q;
    busy       = 1'b0;
    accept     = 1'b0;
    strobe_end = 1'b0;
    case (state_q)
      IDLE: begin
        if (io_rd || io_wr) begin
          accept  = 1'b1;
          busy    = 1'b1;
          state_d = STB1;
        end
      end
      STB1: begin
        busy    = 1'b1;
        state_d = STB2;
      end
      STB2: begin
        busy       = 1'b1;
        strobe_end = 1'b1;
        state_d    = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Reset forces IDLE asynchronously; gating here also drops a stall caused by a held request.
  assign io_busy = busy && !reset;

  always_comb begin
    rd_sel = '0;
    for (int k = 0; k < N_PER; k++) begin
      if (slot_q == 4'(k)) rd_sel = per_d_out[k*IO_DW +: IO_DW];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      per_cs   <= '0;
      per_rd   <= 1'b0;
      per_wr   <= 1'b0;
      per_addr <= '0;
      per_d_in <= '0;
      io_din   <= '0;
      wr_q     <= 1'b0;
      hit_q    <= 1'b0;
      slot_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        per_addr <= offset_of(io_addr);
        per_d_in <= io_dout;
        wr_q     <= io_wr;
        hit_q    <= dec_hit;
        slot_q   <= dec_slot;
        per_cs   <= dec_cs;
        per_wr   <= dec_hit && io_wr;
        per_rd   <= dec_hit && !io_wr;
      end else if (strobe_end) begin
        per_cs <= '0;
        per_rd <= 1'b0;
        per_wr <= 1'b0;
        if (!wr_q) io_din <= hit_q ? rd_sel : '0;
      end
    end
  end

`ifdef BRIDGE_ERR_EN
  logic err_flag;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_flag <= 1'b0;
      err_addr <= '0;
    end else if (accept && !dec_hit) begin
      err_flag <= 1'b1;
      if (!err_flag) err_addr <= io_addr;
    end else if (err_clr) begin
      err_flag <= 1'b0;
    end
  end

  assign err_out = err_flag;
`endif

endmodule

// File: tb/tb_j1_io_bridge.sv
// Self-checking bench for j1_io_bridge: transaction-level model with a per-cycle compare
// process, a two-cycle-strobe responder per slot, directed scenarios and random accesses.
module tb_j1_io_bridge;

  localparam int         N_PER     = 4;
  localparam logic [7:0] BASE_PAGE = 8'h60;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  io_rd, io_wr;
  logic [15:0]           io_addr, io_dout;
  logic [15:0]           io_din;
  logic                  io_busy;
  logic [N_PER-1:0]      per_cs;
  logic [3:0]            per_addr;
  logic                  per_rd, per_wr;
  logic [15:0]           per_d_in;
  logic [16*N_PER-1:0]   per_d_out;
`ifdef BRIDGE_ERR_EN
  logic                  err_clr;
  logic                  err_out;
  logic [15:0]           err_addr;
`endif

  always #5 clk = ~clk;

  j1_io_bridge #(.N_PER(N_PER), .BASE_PAGE(BASE_PAGE)) dut (
    .clk       (clk),
    .reset     (reset),
    .io_rd     (io_rd),
    .io_wr     (io_wr),
    .io_addr   (io_addr),
    .io_dout   (io_dout),
    .io_din    (io_din),
    .io_busy   (io_busy),
    .per_cs    (per_cs),
    .per_addr  (per_addr),
    .per_rd    (per_rd),
    .per_wr    (per_wr),
    .per_d_in  (per_d_in),
    .per_d_out (per_d_out)
`ifdef BRIDGE_ERR_EN
    ,
    .err_clr   (err_clr),
    .err_out   (err_out),
    .err_addr  (err_addr)
`endif
  );

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Environment: register-file responder per slot, acks once per strobe window.
  logic [15:0]      seed;
  logic             resp_init;
  logic [15:0]      resp_mem [N_PER][16];
  logic [15:0]      resp_q   [N_PER];
  logic [N_PER-1:0] blocked;
  int               rd_acks = 0;

  function automatic logic [15:0] init_val(input int k, input int r, input logic [15:0] s);
    if (k == 2 && r == 6) return 16'h00AB;
    return 16'((k * 16 + r) * 40503) ^ s;
  endfunction

  always @(posedge clk) begin
    if (resp_init) begin
      for (int k = 0; k < N_PER; k++) begin
        resp_q[k] <= '0;
        for (int r = 0; r < 16; r++) resp_mem[k][r] <= init_val(k, r, seed);
      end
      blocked <= '0;
    end else begin
      for (int k = 0; k < N_PER; k++) begin
        if (per_cs[k] && !blocked[k]) begin
          if (per_rd) begin
            resp_q[k] <= resp_mem[k][per_addr];
            rd_acks   <= rd_acks + 1;
          end
          if (per_wr) resp_mem[k][per_addr] <= per_d_in;
        end
        blocked[k] <= per_cs[k] && (per_rd || per_wr);
      end
    end
  end

  always_comb begin
    per_d_out = '0;
    for (int k = 0; k < N_PER; k++) per_d_out[k*16 +: 16] = resp_q[k];
  end

  // Behavioural model: one access = 4 cycles (request, strobe, strobe, done).
  logic [15:0] model_mem [N_PER][16];
  logic [15:0] model_din = '0;
  bit          active = 1'b0;
  int          ncyc = 0;
  logic [15:0] t_addr, t_data;
  bit          t_wr;
  bit          model_err = 1'b0;
  logic [15:0] model_err_addr = '0;

  function automatic bit is_hit(input logic [15:0] a);
    return (a[15:8] == BASE_PAGE) && (int'(a[7:4]) < N_PER);
  endfunction

  initial begin : compare
    int  ph;
    bit  strobe, hit;
    logic [3:0] slot, off;
    forever begin
      @(posedge clk);
      #1;
      if (active) begin
        ncyc++;
        ph     = ncyc % 4;
        hit    = is_hit(t_addr);
        slot   = t_addr[7:4];
        off    = t_addr[3:0];
        strobe = (ph == 1) || (ph == 2);
        if (ph == 1 && !hit) begin
          if (!model_err) model_err_addr = t_addr;
          model_err = 1'b1;
        end
        if (ph == 3) begin
          if (t_wr && hit) model_mem[slot][off] = t_data;
          if (!t_wr) model_din = hit ? model_mem[slot][off] : 16'h0000;
        end
        check("busy", io_busy, (ph != 3));
        check("cs", per_cs, (strobe && hit) ? (32'd1 << slot) : 32'd0);
        check("rd", per_rd, strobe && hit && !t_wr);
        check("wr", per_wr, strobe && hit && t_wr);
        if (strobe && hit) begin
          check("addr", per_addr, off);
          if (t_wr) check("d_in", per_d_in, t_data);
        end
      end else begin
        check("idle_busy", io_busy, 0);
        check("idle_cs", per_cs, 0);
        check("idle_strb", {per_rd, per_wr}, 0);
      end
      check("io_din", io_din, model_din);
`ifdef BRIDGE_ERR_EN
      check("err_out", err_out, model_err);
      if (model_err) check("err_addr", err_addr, model_err_addr);
`endif
    end
  end

  int wr_cycles, rd_cycles, busy_cycles;
  logic [N_PER-1:0] cs_seen;

  task automatic sample();
    if (per_wr) wr_cycles++;
    if (per_rd) rd_cycles++;
    if (io_busy) busy_cycles++;
    cs_seen = cs_seen | per_cs;
  endtask

  // Hold one request for n back-to-back accesses, then drop it during the last DONE.
  task automatic access(input logic [15:0] a, input logic [15:0] d, input bit rd, input bit wr,
                        input int n);
    int acks0;
    wr_cycles = 0; rd_cycles = 0; busy_cycles = 0; cs_seen = '0;
    acks0 = rd_acks;
    @(negedge clk);
    io_addr = a; io_dout = d; io_rd = rd; io_wr = wr;
    t_addr = a; t_data = d; t_wr = wr;
    ncyc = 0; active = 1'b1;
    #1;
    check("req_busy", io_busy, 1);
    sample();
    for (int i = 1; i < 4 * n; i++) begin
      @(negedge clk);
      sample();
    end
    io_rd = 1'b0; io_wr = 1'b0; active = 1'b0;
    check("rd_acks", rd_acks - acks0, (is_hit(a) && !wr) ? n : 0);
  endtask

  initial begin
    seed = 16'($urandom);
    reset = 1'b1; resp_init = 1'b1;
    io_rd = 1'b0; io_wr = 1'b0; io_addr = '0; io_dout = '0;
`ifdef BRIDGE_ERR_EN
    err_clr = 1'b0;
`endif
    for (int k = 0; k < N_PER; k++)
      for (int r = 0; r < 16; r++) model_mem[k][r] = init_val(k, r, seed);
    repeat (3) @(negedge clk);
    check("rst_din", io_din, 0);
    check("rst_busy", io_busy, 0);
    check("rst_cs", per_cs, 0);
    check("rst_d_in", per_d_in, 0);
    reset = 1'b0; resp_init = 1'b0;
    @(negedge clk);

    // 1: write to slot 1, offset 4
    access(16'h6014, 16'h1234, 1'b0, 1'b1, 1);
    check("t1_wr_cycles", wr_cycles, 2);
    check("t1_busy_cycles", busy_cycles, 3);
    check("t1_cs", cs_seen, 4'b0010);
    check("t1_rd_cycles", rd_cycles, 0);

    // 2: read slot 2 offset 6, then writes must not disturb io_din
    access(16'h6026, 16'h0000, 1'b1, 1'b0, 1);
    check("t2_din", io_din, 16'h00AB);
    access(16'h6014, 16'h5555, 1'b0, 1'b1, 1);
    access(16'h6032, 16'hAAAA, 1'b0, 1'b1, 1);
    check("t2_hold", io_din, 16'h00AB);

    // 4: simultaneous rd+wr is a write
    access(16'h6000, 16'hBEEF, 1'b1, 1'b1, 1);
    check("t4_rd_cycles", rd_cycles, 0);
    check("t4_wr_cycles", wr_cycles, 2);
    check("t4_din", io_din, 16'h00AB);

    // 3: page miss and slot-range miss
    access(16'h7003, 16'h0000, 1'b1, 1'b0, 1);
    check("t3_cs", cs_seen, 0);
    check("t3_din", io_din, 16'h0000);
    check("t3_busy_cycles", busy_cycles, 3);
    access(16'h6026, 16'h0000, 1'b1, 1'b0, 1);
    access(16'h6050, 16'h0000, 1'b1, 1'b0, 1);
    check("t3b_cs", cs_seen, 0);
    check("t3b_din", io_din, 16'h0000);
`ifdef BRIDGE_ERR_EN
    check("t3_err_out", err_out, 1);
    check("t3_err_addr", err_addr, 16'h7003);
`endif

    // 6: read held across two accesses
    access(16'h6000, 16'h0000, 1'b1, 1'b0, 2);
    check("t6_rd_cycles", rd_cycles, 4);
    check("t6_din", io_din, 16'hBEEF);

    // 5: reset during STB1 of a write
    @(negedge clk);
    io_addr = 16'h6011; io_dout = 16'h7777; io_wr = 1'b1;
    t_addr = 16'h6011; t_data = 16'h7777; t_wr = 1'b1;
    ncyc = 0; active = 1'b1;
    @(posedge clk);
    #3;
    reset = 1'b1; io_wr = 1'b0; active = 1'b0;
    model_din = '0; model_err = 1'b0; model_err_addr = '0;
    #1;
    check("t5_cs", per_cs, 0);
    check("t5_wr", per_wr, 0);
    check("t5_busy", io_busy, 0);
    check("t5_din", io_din, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    access(16'h6011, 16'h0000, 1'b1, 1'b0, 1);
    check("t5_after", io_din, init_val(1, 1, seed));

    // Random accesses
    for (int i = 0; i < 80; i++) begin
      logic [15:0] a;
      int sel;
      case ($urandom_range(0, 3))
        0, 1:    a = {BASE_PAGE, 4'($urandom_range(0, N_PER - 1)), 4'($urandom_range(0, 3))};
        2:       a = {BASE_PAGE, 4'($urandom_range(N_PER, 15)), 4'($urandom_range(0, 15))};
        default: a = 16'($urandom);
      endcase
      sel = $urandom_range(0, 2);
      access(a, 16'($urandom), sel != 1, sel != 0, $urandom_range(1, 2));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
